// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter for the TLP egress path.
// Each class is gated by a header-credit counter. A credit is consumed when a
// packet is granted. A grant stays locked to one requester until its EOP beat
// transfers. There is one idle (bubble) cycle between packets.
module tlp_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int SEL_W          = 2,
  parameter int TLP_DATA_WIDTH = 128,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int CRED_W         = 8,
  parameter int CRED_INIT      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_sop,
  input  logic [NUM_REQ-1:0]                req_eop,
  input  logic [NUM_REQ*TLP_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*TLP_HDR_WIDTH-1:0]  req_hdr,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [TLP_DATA_WIDTH-1:0]         out_data,
  output logic [TLP_HDR_WIDTH-1:0]          out_hdr,
  output logic                              out_valid,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [SEL_W-1:0]                  out_src,
  input  logic                              out_ready,
  input  logic [NUM_REQ-1:0]                cred_ret,
  output logic [NUM_REQ*CRED_W-1:0]         cred_avail,
  output logic                              err_sop
);

  // state | meaning
  // IDLE  | bubble cycle: pick the next winner, consume its credit
  // PKT   | forward the granted requester until its EOP beat transfers
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  logic [0:0]                state;
  logic [SEL_W-1:0]          grant;
  logic [SEL_W-1:0]          last_grant;
  logic [SEL_W-1:0]          winner;
  logic                      win_found;
  logic                      in_pkt;
  logic                      xfer;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        consume;
  logic [CRED_W-1:0]         cred [NUM_REQ];
  logic                      sel_valid;
  logic                      sel_sop;
  logic                      sel_eop;
  logic [TLP_DATA_WIDTH-1:0] sel_data;
  logic [TLP_HDR_WIDTH-1:0]  sel_hdr;

  assign in_pkt = (state == ST_PKT);
  assign xfer   = out_valid & out_ready;

  // Eligibility: a packet start with at least one credit left
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] & req_sop[i] & (cred[i] != '0);
  end

  // Round-robin pick. Indices above last_grant win over the wrapped ones; the lowest index wins within each group.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i] && (SEL_W'(i) <= last_grant)) begin
        win_found = 1'b1;
        winner    = SEL_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i] && (SEL_W'(i) > last_grant)) begin
        win_found = 1'b1;
        winner    = SEL_W'(i);
      end
    end
  end

  // Per-class credit consume strobe (only on the IDLE->PKT transition)
  always_comb begin
    consume = '0;
    for (int i = 0; i < NUM_REQ; i++)
      consume[i] = (state == ST_IDLE) && win_found && (winner == SEL_W'(i));
  end

  // Mux of the granted requester's beat
  always_comb begin
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    sel_hdr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_valid = req_valid[i];
        sel_sop   = req_sop[i];
        sel_eop   = req_eop[i];
        sel_data  = req_data[i*TLP_DATA_WIDTH +: TLP_DATA_WIDTH];
        sel_hdr   = req_hdr[i*TLP_HDR_WIDTH +: TLP_HDR_WIDTH];
      end
    end
  end

  // Egress outputs are forced quiet in IDLE
  always_comb begin
    out_valid = in_pkt & sel_valid;
    out_sop   = in_pkt & sel_sop;
    out_eop   = in_pkt & sel_eop;
    out_src   = in_pkt ? grant : '0;
    out_data  = in_pkt ? sel_data : '0;
    out_hdr   = in_pkt ? sel_hdr : '0;
  end

  // Backpressure passes only to the granted requester
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = in_pkt && (grant == SEL_W'(i)) && out_ready;
  end

  // Flatten the credit counters for observation
  always_comb begin
    cred_avail = '0;
    for (int i = 0; i < NUM_REQ; i++)
      cred_avail[i*CRED_W +: CRED_W] = cred[i];
  end

  // Arbitration FSM, grant bookkeeping and sticky SOP error
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(NUM_REQ - 1);
      err_sop    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|(req_valid & ~req_sop))
            err_sop <= 1'b1;
          if (win_found) begin
            grant <= winner;
            state <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (xfer && out_eop) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credit counters: consume on grant, saturating return, simultaneous events cancel
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst)
        cred[i] <= CRED_W'(CRED_INIT);
      else if (consume[i] && !cred_ret[i])
        cred[i] <= cred[i] - CRED_W'(1);
      else if (cred_ret[i] && !consume[i] && (cred[i] != '1))
        cred[i] <= cred[i] + CRED_W'(1);
    end
  end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: round-robin order, stalls, credits,
// saturation, SOP protocol error and mid-packet reset.
module tb_tlp_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid, req_sop, req_eop, req_ready, cred_ret;
  logic [383:0] req_data, req_hdr;
  logic [127:0] out_data, out_hdr;
  logic         out_valid, out_sop, out_eop, out_ready, err_sop;
  logic [1:0]   out_src;
  logic [23:0]  cred_avail;
  logic [127:0] d [3];
  logic [127:0] h [3];
  int           n_cmp = 0;
  int           n_err = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  assign req_data = {d[2], d[1], d[0]};
  assign req_hdr  = {h[2], h[1], h[0]};

  tlp_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
    .req_data(req_data), .req_hdr(req_hdr), .req_ready(req_ready),
    .out_data(out_data), .out_hdr(out_hdr), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_src(out_src),
    .out_ready(out_ready), .cred_ret(cred_ret), .cred_avail(cred_avail),
    .err_sop(err_sop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input bit v, input bit s, input bit e, input int val);
    req_valid[r] = v;
    req_sop[r]   = s;
    req_eop[r]   = e;
    d[r]         = 128'(val);
    h[r]         = ~128'(val);
  endtask

  // Caller presents the first beat of requester r while the DUT is in IDLE and r is the expected winner.
  task automatic run_pkt(input int r, input int n, input int base);
    #1;
    check("bubble_valid", 128'(out_valid), 128'(0));
    check("bubble_ready", 128'(req_ready), 128'(0));
    tick();
    for (int b = 0; b < n; b++) begin
      drive(r, 1'b1, b == 0, b == n - 1, base + b);
      #1;
      check("pkt_valid", 128'(out_valid), 128'(1));
      check("pkt_src",   128'(out_src),   128'(r));
      check("pkt_sop",   128'(out_sop),   128'(b == 0));
      check("pkt_eop",   128'(out_eop),   128'(b == n - 1));
      check("pkt_data",  out_data,        128'(base + b));
      check("pkt_hdr",   out_hdr,         ~128'(base + b));
      check("pkt_ready", 128'(req_ready), 128'(1 << r));
      tick();
    end
    drive(r, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_sop   = '0;
    req_eop   = '0;
    cred_ret  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = '0;
      h[i] = '0;
    end
    tick();
    tick();
    check("rst_valid", 128'(out_valid),  128'(0));
    check("rst_ready", 128'(req_ready),  128'(0));
    check("rst_cred",  128'(cred_avail), 128'(24'h080808));
    check("rst_err",   128'(err_sop),    128'(0));
    check("rst_src",   128'(out_src),    128'(0));
    rst = 1'b0;

    // All three requesters hold a 2-beat TLP: order 0,1,2
    drive(0, 1'b1, 1'b1, 1'b0, 'h10);
    drive(1, 1'b1, 1'b1, 1'b0, 'h20);
    drive(2, 1'b1, 1'b1, 1'b0, 'h30);
    run_pkt(0, 2, 'h10);
    run_pkt(1, 2, 'h20);
    run_pkt(2, 2, 'h30);
    #1;
    check("t1_cred", 128'(cred_avail), 128'(24'h070707));

    // R1 4-beat TLP with 3-cycle stall on beat 2; R0/R2 waiting must not interleave
    drive(1, 1'b1, 1'b1, 1'b0, 'h100);
    #1;
    check("t2_bubble", 128'(out_valid), 128'(0));
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 'h200);
    drive(2, 1'b1, 1'b1, 1'b0, 'h300);
    #1;
    check("t2_b0_data", out_data, 128'('h100));
    check("t2_b0_src",  128'(out_src), 128'(1));
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, 'h101);
    #1;
    check("t2_b1_data", out_data, 128'('h101));
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, 'h102);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t2_stall_valid", 128'(out_valid), 128'(1));
      check("t2_stall_data",  out_data,        128'('h102));
      check("t2_stall_src",   128'(out_src),   128'(1));
      check("t2_stall_ready", 128'(req_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t2_b2_ready", 128'(req_ready), 128'(3'b010));
    check("t2_b2_data",  out_data,        128'('h102));
    tick();
    drive(1, 1'b1, 1'b0, 1'b1, 'h103);
    #1;
    check("t2_b3_eop",  128'(out_eop), 128'(1));
    check("t2_b3_data", out_data,      128'('h103));
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 0);
    run_pkt(2, 1, 'h300);
    run_pkt(0, 1, 'h200);
    #1;
    check("t2_cred", 128'(cred_avail), 128'(24'h060606));

    // R1 valid without SOP in IDLE: sticky error, R1 never granted, R0 served
    drive(1, 1'b1, 1'b0, 1'b0, 'h400);
    drive(0, 1'b1, 1'b1, 1'b0, 'h500);
    check("t5_err_pre", 128'(err_sop), 128'(0));
    run_pkt(0, 2, 'h500);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t5_err",   128'(err_sop),   128'(1));
      check("t5_valid", 128'(out_valid), 128'(0));
      check("t5_ready", 128'(req_ready), 128'(0));
      tick();
    end
    drive(1, 1'b0, 1'b0, 1'b0, 0);
    #1;
    check("t5_cred", 128'(cred_avail), 128'(24'h060605));

    // Drain R0 credits, then it becomes ineligible until a credit returns
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 'h600 + k);
      run_pkt(0, 1, 'h600 + k);
    end
    #1;
    check("t3_cred_zero", 128'(cred_avail), 128'(24'h060600));
    drive(0, 1'b1, 1'b1, 1'b0, 'h700);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t3_blocked_valid", 128'(out_valid), 128'(0));
      check("t3_blocked_ready", 128'(req_ready), 128'(0));
      tick();
    end
    cred_ret = 3'b001;
    tick();
    cred_ret = 3'b000;
    #1;
    check("t3_cred_ret", 128'(cred_avail), 128'(24'h060601));
    check("t3_still_idle", 128'(out_valid), 128'(0));
    run_pkt(0, 1, 'h700);
    #1;
    check("t3_cred_after", 128'(cred_avail), 128'(24'h060600));

    // R2 saturation at 255, then grant coincident with a return
    cred_ret = 3'b100;
    for (int k = 0; k < 249; k++) tick();
    check("t4_cred_255", 128'(cred_avail), 128'(24'hFF0600));
    tick();
    check("t4_cred_sat", 128'(cred_avail), 128'(24'hFF0600));
    cred_ret = 3'b000;
    drive(2, 1'b1, 1'b1, 1'b1, 'h800);
    cred_ret = 3'b100;
    #1;
    check("t4_coinc_bubble", 128'(out_valid), 128'(0));
    tick();
    cred_ret = 3'b000;
    #1;
    check("t4_coinc_cred",  128'(cred_avail), 128'(24'hFF0600));
    check("t4_coinc_valid", 128'(out_valid),  128'(1));
    check("t4_coinc_src",   128'(out_src),    128'(2));
    tick();
    drive(2, 1'b0, 1'b0, 1'b0, 0);
    #1;
    check("t4_coinc_idle", 128'(out_valid), 128'(0));
    drive(2, 1'b1, 1'b1, 1'b0, 'h900);
    run_pkt(2, 1, 'h900);
    #1;
    check("t4_cred_dec", 128'(cred_avail), 128'(24'hFE0600));

    // Reset on beat 2 of an R0 packet
    cred_ret = 3'b001;
    tick();
    cred_ret = 3'b000;
    drive(0, 1'b1, 1'b1, 1'b0, 'hA00);
    #1;
    check("t6_bubble", 128'(out_valid), 128'(0));
    tick();
    #1;
    check("t6_b0_valid", 128'(out_valid), 128'(1));
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 'hA01);
    #1;
    check("t6_b1_data", out_data, 128'('hA01));
    rst = 1'b1;
    tick();
    check("t6_rst_valid", 128'(out_valid),  128'(0));
    check("t6_rst_ready", 128'(req_ready),  128'(0));
    check("t6_rst_cred",  128'(cred_avail), 128'(24'h080808));
    check("t6_rst_err",   128'(err_sop),    128'(0));
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 'hB00);
    drive(1, 1'b1, 1'b1, 1'b0, 'hB10);
    drive(2, 1'b1, 1'b1, 1'b0, 'hB20);
    run_pkt(0, 1, 'hB00);
    run_pkt(1, 1, 'hB10);
    drive(2, 1'b0, 1'b0, 1'b0, 0);
    #1;
    check("t6_cred_after", 128'(cred_avail), 128'(24'h080707));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
